dp_ctrl_seq: RTL and testbench

Multi-cycle control sequencer that drives the register-file/ALU datapath from the control side. It accepts one 32-bit RV32I instruction at a time over a valid/ready handshake and decodes R-type ALU ops and BEQ/BNE. It sequences register reads, ALU op select and register write-enable, and consumes the datapath Zero flag to resolve branches.

---
 rtl/dp_ctrl_seq_pkg.sv | 64 ++++++
 rtl/dp_ctrl_seq_if.sv | 48 ++++
 rtl/dp_ctrl_seq_instr_decode.sv | 65 ++++++
 rtl/dp_ctrl_seq.sv | 181 ++++++++++++++++++
 tb/tb_dp_ctrl_seq.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dp_ctrl_seq_pkg.sv
//==============================================================================
// Module      : riscv_ctrl_pkg
// Description : Shared constants for the dp_ctrl_seq control sequencer:
//               RV32I opcode/funct fields, ALU op-select codes, FSM state
//               encoding and the instruction classification helpers used by
//               both the sequencer and its decoder.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package riscv_ctrl_pkg;

    // Major opcodes handled by the sequencer
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // funct3 values
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;

    // funct7 values
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ALU op-select encoding ({funct7[5], funct3} for R-type)
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    // FSM state encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_EXEC = 3'd1;
    localparam state_t ST_WB   = 3'd2;
    localparam state_t ST_BR   = 3'd3;
    localparam state_t ST_ILL  = 3'd4;

    // Only the base ALU ops plus SUB/SRA are supported; M-extension
    // (funct7 0000001) and every other funct7 fall out as illegal.
    function automatic logic is_legal_rtype(input logic [6:0] op,
                                            input logic [2:0] f3,
                                            input logic [6:0] f7);
        return (op == OP_RTYPE) &&
               ((f7 == F7_BASE) ||
                ((f7 == F7_ALT) && ((f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA))));
    endfunction

    function automatic logic is_supported_branch(input logic [6:0] op,
                                                 input logic [2:0] f3);
        return (op == OP_BRANCH) && ((f3 == F3_BEQ) || (f3 == F3_BNE));
    endfunction

endpackage

`default_nettype wire

// File: rtl/dp_ctrl_seq_if.sv
//==============================================================================
// Module      : dp_ctrl_seq_if
// Description : Instruction handshake and datapath control bundle between the
//               sequencer (master) and the instruction source / datapath
//               (slave).
//   instr, instr_valid, zero             : source/datapath -> sequencer
//   instr_ready, read_reg_1/2, write_reg,
//   alu_control, write_enable,
//   branch_valid/taken/offset, illegal   : sequencer -> source/datapath
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface dp_ctrl_seq_if #(
    parameter int INSTR_W    = 32,
    parameter int REG_ADDR_W = 5,
    parameter int BR_OFF_W   = 13
) ();

    logic [INSTR_W-1:0]    instr;
    logic                  instr_valid;
    logic                  instr_ready;
    logic                  zero;
    logic [REG_ADDR_W-1:0] read_reg_1;
    logic [REG_ADDR_W-1:0] read_reg_2;
    logic [REG_ADDR_W-1:0] write_reg;
    logic [3:0]            alu_control;
    logic                  write_enable;
    logic                  branch_valid;
    logic                  branch_taken;
    logic [BR_OFF_W-1:0]   branch_offset;
    logic                  illegal;

    modport master (
        input  instr, instr_valid, zero,
        output instr_ready, read_reg_1, read_reg_2, write_reg, alu_control,
               write_enable, branch_valid, branch_taken, branch_offset, illegal
    );

    modport slave (
        output instr, instr_valid, zero,
        input  instr_ready, read_reg_1, read_reg_2, write_reg, alu_control,
               write_enable, branch_valid, branch_taken, branch_offset, illegal
    );

endinterface

`default_nettype wire

// File: rtl/dp_ctrl_seq_instr_decode.sv
//==============================================================================
// Module      : instr_decode
// Description : Purely combinational field decode of the latched instruction.
//   i_instr        : latched RV32I instruction word
//   o_rs1/o_rs2/o_rd : register indices
//   o_alu_control  : ALU op select ({funct7[5],funct3} for R-type, SUB for
//                    branches, ADD otherwise)
//   o_is_rtype/o_is_branch/o_is_bne/o_is_illegal : classification
//   o_b_imm        : sign-extended B-type immediate (bit 0 always 0)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module instr_decode
    import riscv_ctrl_pkg::*;
#(
    parameter int INSTR_W    = 32,
    parameter int REG_ADDR_W = 5,
    parameter int BR_OFF_W   = 13
) (
    input  wire [INSTR_W-1:0]    i_instr,
    output logic [REG_ADDR_W-1:0] o_rs1,
    output logic [REG_ADDR_W-1:0] o_rs2,
    output logic [REG_ADDR_W-1:0] o_rd,
    output logic [3:0]            o_alu_control,
    output logic                  o_is_rtype,
    output logic                  o_is_branch,
    output logic                  o_is_bne,
    output logic                  o_is_illegal,
    output logic [BR_OFF_W-1:0]   o_b_imm
);

    logic [6:0]  w_op;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [12:0] w_imm13;

    assign w_op = i_instr[6:0];
    assign w_f3 = i_instr[14:12];
    assign w_f7 = i_instr[31:25];

    // B-type immediate scatter: {imm[12], imm[11], imm[10:5], imm[4:1], 0}
    assign w_imm13 = {i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};

    always_comb begin
        o_rs1         = REG_ADDR_W'(i_instr[19:15]);
        o_rs2         = REG_ADDR_W'(i_instr[24:20]);
        o_rd          = REG_ADDR_W'(i_instr[11:7]);
        o_is_rtype    = is_legal_rtype(w_op, w_f3, w_f7);
        o_is_branch   = is_supported_branch(w_op, w_f3);
        o_is_bne      = (w_f3 == F3_BNE);
        o_is_illegal  = !o_is_rtype && !o_is_branch;
        o_b_imm       = BR_OFF_W'($signed(w_imm13));
        if (o_is_rtype) begin
            o_alu_control = {w_f7[5], w_f3};
        end else if (o_is_branch) begin
            o_alu_control = ALU_SUB;
        end else begin
            o_alu_control = ALU_ADD;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dp_ctrl_seq.sv
//==============================================================================
// Module      : dp_ctrl_seq
// Description : Multi-cycle control sequencer for a register-file/ALU
//               datapath. Accepts one RV32I instruction at a time, executes
//               R-type ALU ops (EXEC -> WB) and BEQ/BNE (EXEC -> BR), and
//               drops anything else through a one-cycle ILL state. All
//               outputs are Moore (state + latched instruction).
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : dp_ctrl_seq_if.master (handshake + datapath controls)
//   retire_count : (DP_CTRL_RETIRE_CNT_EN only) retired WB/BR count
// Optional    : define DP_CTRL_RETIRE_CNT_EN to add the retire counter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dp_ctrl_seq
    import riscv_ctrl_pkg::*;
#(
    parameter int INSTR_W    = 32,
    parameter int REG_ADDR_W = 5,
    parameter int BR_OFF_W   = 13
) (
    input  wire           clk,
    input  wire           reset,
    dp_ctrl_seq_if.master bus
`ifdef DP_CTRL_RETIRE_CNT_EN
    ,
    output logic [31:0]   retire_count
`endif
);

    state_t               r_state;
    state_t               w_next_state;
    logic [INSTR_W-1:0]   r_instr;
    logic                 r_zero_q;

    logic [REG_ADDR_W-1:0] w_rs1;
    logic [REG_ADDR_W-1:0] w_rs2;
    logic [REG_ADDR_W-1:0] w_rd;
    logic [3:0]            w_alu_control;
    logic                  w_is_rtype;
    logic                  w_is_branch;
    logic                  w_is_bne;
    logic                  w_is_illegal;
    logic [BR_OFF_W-1:0]   w_b_imm;

    logic                  w_accept;
    logic                  w_in_rtype;
    logic                  w_in_branch;

    // Only the accept decision looks at the live instruction; everything
    // driven to the datapath comes from the latched copy.
    assign w_accept    = bus.instr_valid && (r_state == ST_IDLE);
    assign w_in_rtype  = is_legal_rtype(bus.instr[6:0], bus.instr[14:12], bus.instr[31:25]);
    assign w_in_branch = is_supported_branch(bus.instr[6:0], bus.instr[14:12]);

    instr_decode #(
        .INSTR_W    (INSTR_W),
        .REG_ADDR_W (REG_ADDR_W),
        .BR_OFF_W   (BR_OFF_W)
    ) u_decode (
        .i_instr       (r_instr),
        .o_rs1         (w_rs1),
        .o_rs2         (w_rs2),
        .o_rd          (w_rd),
        .o_alu_control (w_alu_control),
        .o_is_rtype    (w_is_rtype),
        .o_is_branch   (w_is_branch),
        .o_is_bne      (w_is_bne),
        .o_is_illegal  (w_is_illegal),
        .o_b_imm       (w_b_imm)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Instruction register and branch Zero capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr  <= '0;
            r_zero_q <= 1'b0;
        end else begin
            if (w_accept) begin
                r_instr <= bus.instr;
            end
            // Zero reflects the SUB driven during EXEC; hold it for BR.
            if ((r_state == ST_EXEC) && w_is_branch) begin
                r_zero_q <= bus.zero;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_in_rtype || w_in_branch) begin
                        w_next_state = ST_EXEC;
                    end else begin
                        w_next_state = ST_ILL;
                    end
                end
            end
            ST_EXEC: w_next_state = w_is_rtype ? ST_WB : ST_BR;
            ST_WB:   w_next_state = ST_IDLE;
            ST_BR:   w_next_state = ST_IDLE;
            ST_ILL:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.instr_ready   = 1'b0;
        bus.read_reg_1    = '0;
        bus.read_reg_2    = '0;
        bus.write_reg     = '0;
        bus.alu_control   = ALU_ADD;
        bus.write_enable  = 1'b0;
        bus.branch_valid  = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_offset = '0;
        bus.illegal       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.instr_ready = 1'b1;
            end
            ST_EXEC: begin
                bus.read_reg_1  = w_rs1;
                bus.read_reg_2  = w_rs2;
                bus.alu_control = w_alu_control;
            end
            ST_WB: begin
                bus.read_reg_1   = w_rs1;
                bus.read_reg_2   = w_rs2;
                bus.alu_control  = w_alu_control;
                bus.write_reg    = w_rd;
                // x0 is hardwired; never strobe a write to it.
                bus.write_enable = (w_rd != '0);
            end
            ST_BR: begin
                bus.branch_valid  = 1'b1;
                bus.branch_taken  = w_is_bne ? !r_zero_q : r_zero_q;
                bus.branch_offset = w_b_imm;
            end
            ST_ILL: begin
                bus.illegal = w_is_illegal;
            end
            default: begin
                bus.instr_ready = 1'b0;
            end
        endcase
    end

`ifdef DP_CTRL_RETIRE_CNT_EN
    logic [31:0] r_retire_count;

    // Counts completed WB/BR states; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retire_count <= '0;
        end else if ((r_state == ST_WB) || (r_state == ST_BR)) begin
            r_retire_count <= r_retire_count + 32'd1;
        end
    end

    assign retire_count = r_retire_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dp_ctrl_seq.sv
//==============================================================================
// Module      : tb_dp_ctrl_seq
// Description : Self-checking bench for dp_ctrl_seq: reset state, a table of
//               directed instructions, a mid-WB asynchronous reset sequence,
//               and random instruction streams against a trace-based model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dp_ctrl_seq;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dp_ctrl_seq_if u_if ();

    dp_ctrl_seq u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    typedef struct packed {
        logic        rdy;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  wr;
        logic [3:0]  alu;
        logic        we;
        logic        bv;
        logic        bt;
        logic [12:0] off;
        logic        ill;
    } out_t;

    typedef struct packed {
        out_t o;
        logic zf;   // force zero input during this cycle
        logic zv;
    } ent_t;

    typedef struct {
        logic [31:0] ins;
        logic        z;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [3:0]  alu;
        logic [4:0]  wr;
        logic        we;
        logic        bv;
        logic        bt;
        logic [12:0] off;
        logic        ill;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    ent_t q[$];

    function automatic out_t sample();
        out_t a;
        a.rdy = u_if.instr_ready;
        a.r1  = u_if.read_reg_1;
        a.r2  = u_if.read_reg_2;
        a.wr  = u_if.write_reg;
        a.alu = u_if.alu_control;
        a.we  = u_if.write_enable;
        a.bv  = u_if.branch_valid;
        a.bt  = u_if.branch_taken;
        a.off = u_if.branch_offset;
        a.ill = u_if.illegal;
        return a;
    endfunction

    function automatic out_t idle_out();
        out_t o = '0;
        o.rdy = 1'b1;
        return o;
    endfunction

    function automatic string fmt(input out_t o);
        return $sformatf("rdy=%0b r1=%0d r2=%0d wr=%0d alu=%b we=%0b bv=%0b bt=%0b off=%h ill=%0b",
                         o.rdy, o.r1, o.r2, o.wr, o.alu, o.we, o.bv, o.bt, o.off, o.ill);
    endfunction

    task automatic chk(input string name, input out_t act, input out_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got {%s} want {%s}", name, $time, fmt(act), fmt(exp));
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0b want %0b", name, $time, act, exp);
        end
    endtask

    // Reference model: expands one accepted instruction into the sequence of
    // per-cycle outputs it should produce after acceptance.
    function automatic void build_trace(input logic [31:0] ins, input logic zx);
        logic [6:0] op  = ins[6:0];
        logic [2:0] f3  = ins[14:12];
        logic [6:0] f7  = ins[31:25];
        logic       is_r;
        logic       is_b;
        int         imm;
        ent_t       e1  = '0;
        ent_t       e2  = '0;
        is_r = (op == 7'h33) && ((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
        is_b = (op == 7'h63) && (f3 <= 3'd1);
        if (is_r) begin
            e1.o.r1  = ins[19:15];
            e1.o.r2  = ins[24:20];
            e1.o.alu = {f7[5], f3};
            e2       = e1;
            e2.o.wr  = ins[11:7];
            e2.o.we  = (ins[11:7] != 5'd0);
            q.push_back(e1);
            q.push_back(e2);
        end else if (is_b) begin
            e1.o.r1  = ins[19:15];
            e1.o.r2  = ins[24:20];
            e1.o.alu = 4'd8;
            e1.zf    = 1'b1;
            e1.zv    = zx;
            imm = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048
                + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
            e2.o.bv  = 1'b1;
            e2.o.bt  = (f3 == 3'd0) ? zx : !zx;
            e2.o.off = imm[12:0];
            q.push_back(e1);
            q.push_back(e2);
        end else begin
            e1.o.ill = 1'b1;
            q.push_back(e1);
        end
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 3))
            0: begin
                r[6:0] = 7'h33;
                if ($urandom_range(0, 1) == 0) begin
                    r[31:25] = 7'h00;
                end else begin
                    r[31:25] = 7'h20;
                    r[14:12] = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd5;
                end
            end
            1: begin
                r[6:0]   = 7'h63;
                r[14:12] = 3'($urandom_range(0, 2));
            end
            2: r[6:0] = 7'h33;
            default: ;
        endcase
        return r;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        out_t e1 = '0;
        out_t e2 = '0;
        if (v.ill) begin
            e1.ill = 1'b1;
            e2     = idle_out();
        end else if (v.bv) begin
            e1.r1  = v.r1;
            e1.r2  = v.r2;
            e1.alu = v.alu;
            e2.bv  = 1'b1;
            e2.bt  = v.bt;
            e2.off = v.off;
        end else begin
            e1.r1  = v.r1;
            e1.r2  = v.r2;
            e1.alu = v.alu;
            e2     = e1;
            e2.wr  = v.wr;
            e2.we  = v.we;
        end
        @(posedge clk); #1;
        u_if.instr       = v.ins;
        u_if.instr_valid = 1'b1;
        u_if.zero        = !v.z;
        @(negedge clk);
        chk_bit($sformatf("vec%0d_accept_ready", idx), u_if.instr_ready, 1'b1);
        @(posedge clk); #1;
        u_if.instr_valid = 1'b0;
        u_if.instr       = $urandom;
        u_if.zero        = v.z;
        @(negedge clk);
        chk($sformatf("vec%0d_cycle1", idx), sample(), e1);
        @(posedge clk); #1;
        u_if.zero = !v.z;
        @(negedge clk);
        chk($sformatf("vec%0d_cycle2", idx), sample(), e2);
        if (!v.ill) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("vec%0d_cycle3", idx), sample(), idle_out());
        end
    endtask

    initial begin
        vec_t vecs[12];
        vec_t add_v;
        logic        pend;
        logic [31:0] pins;
        ent_t        e;

        //            ins           z     r1     r2     alu    wr     we    bv    bt    off        ill
        vecs[0]  = '{32'h002081B3, 1'b0, 5'd1,  5'd2,  4'h0,  5'd3,  1'b1, 1'b0, 1'b0, 13'h0000, 1'b0}; // ADD
        vecs[1]  = '{32'h407302B3, 1'b0, 5'd6,  5'd7,  4'h8,  5'd5,  1'b1, 1'b0, 1'b0, 13'h0000, 1'b0}; // SUB
        vecs[2]  = '{32'h00208463, 1'b1, 5'd1,  5'd2,  4'h8,  5'd0,  1'b0, 1'b1, 1'b1, 13'h0008, 1'b0}; // BEQ z=1
        vecs[3]  = '{32'h00209463, 1'b1, 5'd1,  5'd2,  4'h8,  5'd0,  1'b0, 1'b1, 1'b0, 13'h0008, 1'b0}; // BNE z=1
        vecs[4]  = '{32'h00208033, 1'b0, 5'd1,  5'd2,  4'h0,  5'd0,  1'b0, 1'b0, 1'b0, 13'h0000, 1'b0}; // ADD x0
        vecs[5]  = '{32'h00000000, 1'b0, 5'd0,  5'd0,  4'h0,  5'd0,  1'b0, 1'b0, 1'b0, 13'h0000, 1'b1}; // zero word
        vecs[6]  = '{32'h022081B3, 1'b0, 5'd0,  5'd0,  4'h0,  5'd0,  1'b0, 1'b0, 1'b0, 13'h0000, 1'b1}; // MUL
        vecs[7]  = '{32'h4020D233, 1'b0, 5'd1,  5'd2,  4'hD,  5'd4,  1'b1, 1'b0, 1'b0, 13'h0000, 1'b0}; // SRA
        vecs[8]  = '{32'hFE208EE3, 1'b0, 5'd1,  5'd2,  4'h8,  5'd0,  1'b0, 1'b1, 1'b0, 13'h1FFC, 1'b0}; // BEQ -4 z=0
        vecs[9]  = '{32'h402091B3, 1'b0, 5'd0,  5'd0,  4'h0,  5'd0,  1'b0, 1'b0, 1'b0, 13'h0000, 1'b1}; // alt-f7 SLL
        vecs[10] = '{32'h00209463, 1'b0, 5'd1,  5'd2,  4'h8,  5'd0,  1'b0, 1'b1, 1'b1, 13'h0008, 1'b0}; // BNE z=0
        vecs[11] = '{32'h01DF4FB3, 1'b0, 5'd30, 5'd29, 4'h4,  5'd31, 1'b1, 1'b0, 1'b0, 13'h0000, 1'b0}; // XOR x31
        add_v    = vecs[0];

        reset            = 1'b0;
        u_if.instr       = 32'h002081B3;
        u_if.instr_valid = 1'b1;
        u_if.zero        = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_state", sample(), idle_out());
        @(posedge clk); #1;
        u_if.instr_valid = 1'b0;
        reset            = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", sample(), idle_out());

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], i);
        end

        // Asynchronous reset asserted in the middle of WB
        @(posedge clk); #1;
        u_if.instr       = 32'h002081B3;
        u_if.instr_valid = 1'b1;
        @(posedge clk); #1;
        u_if.instr_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk_bit("midwb_we_before_reset", u_if.write_enable, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("midwb_async_reset", sample(), idle_out());
        @(posedge clk); #1;
        @(negedge clk);
        chk("midwb_held_in_reset", sample(), idle_out());
        @(posedge clk); #1;
        reset = 1'b1;
        run_vec(add_v, 100);

        // Random stream; instructions are held until accepted.
        pend = 1'b0;
        pins = '0;
        q.delete();
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            if (!pend && ($urandom_range(0, 1) == 1)) begin
                pend = 1'b1;
                pins = gen_instr();
            end
            u_if.instr_valid = pend;
            u_if.instr       = pend ? pins : $urandom;
            if (q.size() > 0) begin
                e = q.pop_front();
            end else begin
                e      = '0;
                e.o    = idle_out();
            end
            u_if.zero = e.zf ? e.zv : 1'($urandom_range(0, 1));
            @(negedge clk);
            chk($sformatf("rand_c%0d_ins%08h", c, pins), sample(), e.o);
            if (e.o.rdy && pend) begin
                build_trace(pins, 1'($urandom_range(0, 1)));
                pend = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
